// File: rtl/wb_trace_monitor.sv
// ---------------------------------------------------------------------------
// wb_trace_monitor
//
// Passive observer for the pipeline writeback debug interface. It keeps a
// shadow copy of the architectural register file and records every committed
// register write into a sequence-numbered trace FIFO. A checker or host drains
// that FIFO over a valid/ready stream. The monitor never drives the core.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   wb_reg_write_i    writeback strobe from the pipeline
//   wb_rd_addr_i      writeback destination register (x0 writes are ignored)
//   wb_result_i       writeback value
//   capture_en_i      allows trace pushes and sequence counting
//   clear_i           flushes the trace FIFO and clears overflow state
//   trace_valid_o     head entry available
//   trace_ready_i     consumer accepts the head entry
//   trace_seq_o       sequence number of the head entry (0 when not valid)
//   trace_rd_o        destination register of the head entry (0 when not valid)
//   trace_data_o      value of the head entry (0 when not valid)
//   fifo_count_o      trace FIFO occupancy
//   overflow_o        sticky flag, at least one event was dropped
//   overflow_cnt_o    saturating count of dropped events
//   shadow_raddr_i    shadow register file read address
//   shadow_rdata_o    shadow register file read data (combinational)
// ---------------------------------------------------------------------------
module wb_trace_monitor #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 8,
    parameter int SEQ_WIDTH      = 16,
    parameter int OVF_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0]     wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]         wb_result_i,
    input  logic                          capture_en_i,
    input  logic                          clear_i,
    output logic                          trace_valid_o,
    input  logic                          trace_ready_i,
    output logic [SEQ_WIDTH-1:0]          trace_seq_o,
    output logic [REG_ADDR_WIDTH-1:0]     trace_rd_o,
    output logic [DATA_WIDTH-1:0]         trace_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic [OVF_WIDTH-1:0]          overflow_cnt_o,
    input  logic [REG_ADDR_WIDTH-1:0]     shadow_raddr_i,
    output logic [DATA_WIDTH-1:0]         shadow_rdata_o
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     shadow_rf [NUM_REGS];

    logic [SEQ_WIDTH-1:0]      seq_mem  [FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [CNT_W-1:0]          count;
    logic [SEQ_WIDTH-1:0]      seq;
    logic                      overflow;
    logic [OVF_WIDTH-1:0]      ovf_cnt;

    logic                      wb_event;
    logic                      capture;
    logic                      fifo_full;
    logic                      pop;
    logic                      push;
    logic                      drop;

    // Event qualification. A full FIFO still accepts a push when the head is
    // being popped in the same cycle, since the freed slot is the one the
    // write pointer already points at.
    assign wb_event  = wb_reg_write_i && (wb_rd_addr_i != '0);
    assign capture   = wb_event && capture_en_i;
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = trace_valid_o && trace_ready_i;
    assign push      = capture && (!fifo_full || pop);
    assign drop      = capture && fifo_full && !pop;

    // Shadow register file tracks every non-x0 writeback, independent of
    // capture_en_i and clear_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_rf[i] <= '0;
            end
        end else if (wb_event) begin
            shadow_rf[wb_rd_addr_i] <= wb_result_i;
        end
    end

    // Trace storage needs no reset: head outputs are gated by trace_valid_o,
    // and a write during clear_i lands in a slot the reset pointers ignore.
    always_ff @(posedge clk) begin
        if (push) begin
            seq_mem[wr_ptr]  <= seq;
            rd_mem[wr_ptr]   <= wb_rd_addr_i;
            data_mem[wr_ptr] <= wb_result_i;
        end
    end

    // Sequence number advances on every captured event, pushed or dropped,
    // so consumers can spot drops as gaps. clear_i leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= '0;
        end else if (capture) begin
            seq <= seq + SEQ_WIDTH'(1);
        end
    end

    // FIFO pointers, occupancy and overflow state. clear_i overrides any
    // push, pop or drop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_cnt != '1) begin
                    ovf_cnt <= ovf_cnt + OVF_WIDTH'(1);
                end
            end
        end
    end

    assign trace_valid_o  = (count != '0);
    assign trace_seq_o    = trace_valid_o ? seq_mem[rd_ptr]  : '0;
    assign trace_rd_o     = trace_valid_o ? rd_mem[rd_ptr]   : '0;
    assign trace_data_o   = trace_valid_o ? data_mem[rd_ptr] : '0;
    assign fifo_count_o   = count;
    assign overflow_o     = overflow;
    assign overflow_cnt_o = ovf_cnt;

    assign shadow_rdata_o = (shadow_raddr_i == '0) ? '0 : shadow_rf[shadow_raddr_i];

endmodule

// File: doc/wb_trace_monitor.md
Name: wb_trace_monitor

Overview:
- Passive observer attached to the pipeline's writeback debug interface (reg-write strobe, destination register, result).
- Keeps a shadow copy of the architectural register file, so tests need not peek into the register file hierarchy.
- Records every committed register write into a sequence-numbered trace FIFO, drained by a checker or host over a valid/ready stream.
- Sits beside the pipeline in simulation and FPGA debug builds. It never drives the core.

Parameters:
- DATA_WIDTH, 32, width of result and shadow registers
- REG_ADDR_WIDTH, 5, register index width (2**REG_ADDR_WIDTH shadow entries)
- FIFO_DEPTH, 8, trace entries; must be a power of 2 and at least 2
- SEQ_WIDTH, 16, width of the commit sequence number
- OVF_WIDTH, 16, width of the dropped-event counter

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- wb_reg_write_i  input  1  writeback strobe from the pipeline
- wb_rd_addr_i  input  REG_ADDR_WIDTH  writeback destination register
- wb_result_i  input  DATA_WIDTH  writeback value
- capture_en_i  input  1  allows FIFO pushes; the shadow RF updates regardless
- clear_i  input  1  flushes the FIFO and clears overflow state
- trace_valid_o  output  1  head entry is available
- trace_ready_i  input  1  consumer accepts the head entry
- trace_seq_o  output  SEQ_WIDTH  sequence number of the head entry
- trace_rd_o  output  REG_ADDR_WIDTH  destination register of the head entry
- trace_data_o  output  DATA_WIDTH  value of the head entry
- fifo_count_o  output  $clog2(FIFO_DEPTH)+1  occupancy
- overflow_o  output  1  sticky: at least one event was dropped
- overflow_cnt_o  output  OVF_WIDTH  dropped events, saturating
- shadow_raddr_i  input  REG_ADDR_WIDTH  shadow RF read address
- shadow_rdata_o  output  DATA_WIDTH  shadow RF read data

Behaviour:
- Event definition:
  - event = wb_reg_write_i && (wb_rd_addr_i != 0).
  - Writes to x0 are ignored everywhere: no shadow update, no sequence increment, no push.
- Shadow RF:
  - On an event, shadow[rd] <= result at the clock edge.
  - Read is combinational: shadow_rdata_o = shadow[shadow_raddr_i].
  - No write-to-read bypass; a written value is visible starting the cycle after the edge.
  - Entry 0 always reads 0.
- Sequence counter:
  - Increments by 1 on every event while capture_en_i=1, whether the event is pushed or dropped.
  - Consumers detect drops as gaps in trace_seq_o.
  - The pushed entry carries the pre-increment value.
  - Wraps modulo 2**SEQ_WIDTH.
  - Reset only by rst; clear_i does not affect it.
- Push condition: event && capture_en_i && (not full || pop in the same cycle).
- Pop condition: trace_valid_o && trace_ready_i.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy counter.
  - Simultaneous push and pop leaves occupancy unchanged. This is legal when full and when holding exactly 1 entry.
  - A push into an empty FIFO produces trace_valid_o=1 the following cycle (latency 1). There is no same-cycle fall-through.
- Head outputs:
  - trace_seq_o, trace_rd_o and trace_data_o reflect the entry at the read pointer.
  - They are driven to 0 whenever trace_valid_o=0.
  - They stay stable while trace_valid_o=1 and trace_ready_i=0.
- Overflow:
  - Occurs when event && capture_en_i, FIFO full, and no pop in that cycle.
  - The event is dropped, overflow_o is set, and overflow_cnt_o increments, saturating at all-ones.
- clear_i:
  - Takes effect on the next edge: pointers, occupancy, overflow_o and overflow_cnt_o go to 0.
  - Overrides any push or pop in that cycle; a push in that cycle is discarded without counting as overflow.
  - The shadow RF and sequence counter are unaffected.
- Reset (rst=1 at an edge), including mid-operation:
  - All shadow entries, pointers, occupancy, sequence counter and overflow state go to 0.
  - Outputs after reset: trace_valid_o=0, head outputs=0, fifo_count_o=0, overflow_o=0, overflow_cnt_o=0, shadow_rdata_o=0.
  - rst takes priority over clear_i and all events.
- capture_en_i=0: no push, no sequence increment, no overflow counting. Pops continue normally.

Test Plan:
- Reset, then writes x1=0x11, x2=0x22, x0=0xFF with trace_ready_i=0 -> fifo_count_o=2; head is seq0/rd1/0x11; shadow[2]=0x22 the cycle after its edge; shadow[0]=0.
- Drain at trace_ready_i=1 -> entries (0,1,0x11) then (1,2,0x22) on consecutive cycles; trace_valid_o=0 after; head outputs=0.
- FIFO_DEPTH=8, 10 events with ready=0 -> count=8; overflow_o=1; overflow_cnt_o=2; after drain the last seq seen is 7; the next event pushes seq 10.
- FIFO full, event with ready=1 in the same cycle -> push accepted; count stays 8; no overflow increment.
- clear_i asserted together with an event -> count=0 and overflow_cnt_o=0 next cycle; event not stored; shadow still updated; next event pushes seq+1.
- rst asserted with 5 entries queued and a write in flight -> everything returns to 0; shadow[1]=0; first event after reset gets seq0.
